// File: rtl/fcvt_seq_ctrl_if.sv
// Request/response bundle between FP issue, the FCVT sequencer and writeback.
interface fcvt_seq_ctrl_if #(
  parameter int unsigned TAG_W = 5
) ();
  localparam int unsigned DATA_W = 32;

  logic              req_valid;
  logic              req_ready;
  logic              req_op;
  logic              req_unsigned;
  logic [TAG_W-1:0]  req_tag;
  logic [DATA_W-1:0] req_src;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_to_fp;

  // Issue/writeback side
  modport master (
    output req_valid, req_op, req_unsigned, req_tag, req_src, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_tag, rsp_to_fp
  );

  // Sequencer side
  modport slave (
    input  req_valid, req_op, req_unsigned, req_tag, req_src, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_tag, rsp_to_fp
  );
endinterface

// File: rtl/fcvt_seq_ctrl.sv
// Multi-cycle FP<->INT conversion sequencer (FCVT.S.W/WU, FCVT.W/WU.S).
// INT->FLOAT normalises one bit per cycle with truncation; FLOAT->INT takes
// one execute cycle. Result is held until writeback accepts it; flush aborts.
module fcvt_seq_ctrl #(
  parameter int unsigned TAG_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  output logic            busy,
  fcvt_seq_ctrl_if.slave  bus
);

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned EXP_W    = 8;
  localparam logic [EXP_W-1:0] EXP_TOP = 8'd158;  // bias + 31

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    I2F_NORM = 2'd1,
    F2I_EXEC = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] work;      // I2F: magnitude being normalised; F2I: raw source
  logic [EXP_W-1:0]  exp_q;
  logic              sign_q;
  logic              uns_q;
  logic [TAG_W-1:0]  tag_q;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_to_fp;

  logic              req_ready;
  logic              i2f_sign;
  logic [DATA_W-1:0] i2f_mag;

  // Truncating float->int with 32-bit wrap; NaN/Inf take the same path
  function automatic logic [DATA_W-1:0] f2i(input logic [DATA_W-1:0] x,
                                            input logic uns);
    logic              s;
    logic [EXP_W-1:0]  e;
    logic [63:0]       m;
    logic [DATA_W-1:0] mag;
    logic [DATA_W-1:0] res;
    s = x[31];
    e = x[30:23];
    m = {40'd0, 1'b1, x[22:0]};
    if (e < 8'd127)      mag = '0;
    else if (e < 8'd150) mag = 32'(m >> (8'd150 - e));
    else if (e < 8'd183) mag = 32'(m << (e - 8'd150));
    else                 mag = '0;
    if (uns) res = s ? '0 : mag;
    else     res = s ? (~mag + 32'd1) : mag;
    return res;
  endfunction

  // Sign/magnitude split of an incoming integer operand
  assign i2f_sign = !bus.req_unsigned && bus.req_src[31];
  assign i2f_mag  = i2f_sign ? (~bus.req_src + 32'd1) : bus.req_src;

  // Accept only from IDLE, never during flush or reset
  assign req_ready = rst_n && (state == IDLE) && !flush;
  assign busy      = (state != IDLE);

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data;
  assign bus.rsp_tag   = rsp_tag;
  assign bus.rsp_to_fp = rsp_to_fp;

  // Sequencer state, datapath and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      work      <= '0;
      exp_q     <= '0;
      sign_q    <= 1'b0;
      uns_q     <= 1'b0;
      tag_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
      rsp_to_fp <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            uns_q <= bus.req_unsigned;
            tag_q <= bus.req_tag;
            if (!bus.req_op) begin
              sign_q <= i2f_sign;
              work   <= i2f_mag;
              exp_q  <= EXP_TOP;
              if (bus.req_src == '0) begin
                state     <= DONE;
                rsp_valid <= 1'b1;
                rsp_data  <= '0;
                rsp_tag   <= bus.req_tag;
                rsp_to_fp <= 1'b1;
              end else begin
                state <= I2F_NORM;
              end
            end else begin
              work  <= bus.req_src;
              state <= F2I_EXEC;
            end
          end
        end
        I2F_NORM: begin
          if (work[31]) begin
            state     <= DONE;
            rsp_valid <= 1'b1;
            rsp_data  <= {sign_q, exp_q, work[30:8]};
            rsp_tag   <= tag_q;
            rsp_to_fp <= 1'b1;
          end else begin
            work  <= work << 1;
            exp_q <= exp_q - 8'd1;
          end
        end
        F2I_EXEC: begin
          state     <= DONE;
          rsp_valid <= 1'b1;
          rsp_data  <= f2i(work, uns_q);
          rsp_tag   <= tag_q;
          rsp_to_fp <= 1'b0;
        end
        DONE: begin
          if (bus.rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fcvt_seq_ctrl.sv
// Randomised self-checking bench for fcvt_seq_ctrl against a value-level model.
module tb_fcvt_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic busy;
  int   n_chk  = 0;
  int   n_pass = 0;

  fcvt_seq_ctrl_if #(.TAG_W(5)) bus ();

  fcvt_seq_ctrl #(.TAG_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Int->float by locating the leading one; returns expected latency too
  function automatic logic [31:0] ref_i2f(input logic [31:0] src, input logic uns,
                                          output int lat);
    logic        neg;
    logic [31:0] mag;
    logic [31:0] norm;
    int          msb;
    if (src == 32'd0) begin
      lat = 1;
      return 32'd0;
    end
    neg = !uns && src[31];
    mag = neg ? (32'd0 - src) : src;
    msb = 0;
    for (int k = 0; k < 32; k++) if (mag[k]) msb = k;
    norm = mag << (31 - msb);
    lat  = 2 + (31 - msb);
    return {neg, 8'(127 + msb), norm[30:8]};
  endfunction

  // Float->int: scale significand by 2^150 in a wide word, pick integer bits
  function automatic logic [31:0] ref_f2i(input logic [31:0] src, input logic uns);
    logic [299:0] big;
    logic [31:0]  mag;
    big = 300'({1'b1, src[22:0]}) << src[30:23];
    mag = big[150 +: 32];
    if (uns) return src[31] ? 32'd0 : mag;
    return src[31] ? (32'd0 - mag) : mag;
  endfunction

  // Present a request and wait (bounded) until it is accepted
  task automatic send(input logic op, input logic uns, input logic [31:0] src,
                      input logic [4:0] tag);
    int n;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_op       = op;
    bus.req_unsigned = uns;
    bus.req_src      = src;
    bus.req_tag      = tag;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  // Called 1 time unit after the accept edge; counts cycles to rsp_valid
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!bus.rsp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Full transaction with rsp_ready held high
  task automatic run(input logic op, input logic uns, input logic [31:0] src,
                     input logic [4:0] tag);
    int          lat;
    int          exp_lat;
    logic [31:0] exp_d;
    if (op) begin
      exp_d   = ref_f2i(src, uns);
      exp_lat = 2;
    end else begin
      exp_d = ref_i2f(src, uns, exp_lat);
    end
    send(op, uns, src, tag);
    wait_rsp(lat);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("rsp_data", bus.rsp_data, exp_d);
    chk("rsp_tag", 32'(bus.rsp_tag), 32'(tag));
    chk("rsp_to_fp", 32'(bus.rsp_to_fp), 32'(!op));
    @(posedge clk);
    #1;
    chk("idle_after_rsp", {bus.rsp_valid, busy}, 32'd0);
  endtask

  initial begin
    int          lat;
    int          cnt;
    logic [31:0] r;
    logic [31:0] exp_d;

    rst_n            = 1'b0;
    flush            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_op       = 1'b0;
    bus.req_unsigned = 1'b0;
    bus.req_src      = 32'd0;
    bus.req_tag      = 5'd0;
    bus.rsp_ready    = 1'b1;

    // Reset state
    #12;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.req_ready), 32'd1);

    // Directed conversions
    run(1'b0, 1'b0, 32'h0000_0001, 5'd1);
    run(1'b0, 1'b0, 32'hFFFF_FFFF, 5'd2);
    run(1'b0, 1'b1, 32'h8000_0000, 5'd3);
    run(1'b0, 1'b0, 32'h8000_0000, 5'd4);
    run(1'b0, 1'b0, 32'h0000_0000, 5'd5);
    run(1'b1, 1'b0, 32'h4049_0FDB, 5'd6);
    run(1'b1, 1'b0, 32'hC049_0FDB, 5'd7);
    run(1'b1, 1'b1, 32'hC049_0FDB, 5'd8);
    run(1'b1, 1'b0, 32'h3F00_0000, 5'd9);
    run(1'b1, 1'b0, 32'h7F80_0000, 5'd10);
    run(1'b1, 1'b1, 32'h4F80_0001, 5'd11);

    // Backpressure: result held, second request blocked until release
    bus.rsp_ready = 1'b0;
    send(1'b0, 1'b0, 32'h0000_0123, 5'd12);
    exp_d = ref_i2f(32'h0000_0123, 1'b0, cnt);
    wait_rsp(lat);
    chk("bp_latency", 32'(lat), 32'(cnt));
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_op       = 1'b1;
    bus.req_unsigned = 1'b0;
    bus.req_src      = 32'hC049_0FDB;
    bus.req_tag      = 5'd13;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_data", bus.rsp_data, exp_d);
      chk("bp_tag", 32'(bus.rsp_tag), 32'd12);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_idle", {bus.rsp_valid, busy}, 32'd0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("bp_second_accepted", 32'(busy), 32'd1);
    wait_rsp(lat);
    chk("bp2_latency", 32'(lat), 32'd2);
    chk("bp2_data", bus.rsp_data, 32'hFFFF_FFFD);
    chk("bp2_tag", 32'(bus.rsp_tag), 32'd13);
    @(posedge clk);
    #1;

    // Flush during normalisation: no response for that tag
    send(1'b0, 1'b0, 32'h0000_0001, 5'd14);
    repeat (3) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_idle", {bus.rsp_valid, busy}, 32'd0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) cnt++;
    end
    chk("flush_no_rsp", 32'(cnt), 32'd0);

    // Flush in DONE with rsp_ready high, competing request not accepted
    send(1'b1, 1'b0, 32'h4049_0FDB, 5'd15);
    wait_rsp(lat);
    chk("fd_data", bus.rsp_data, 32'd3);
    @(negedge clk);
    flush            = 1'b1;
    bus.req_valid    = 1'b1;
    bus.req_op       = 1'b1;
    bus.req_src      = 32'h4049_0FDB;
    bus.req_tag      = 5'd16;
    chk("fd_req_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("fd_dropped", {bus.rsp_valid, busy}, 32'd0);
    flush         = 1'b0;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("fd_no_accept", 32'(busy), 32'd0);

    // Asynchronous reset mid-normalisation
    send(1'b0, 1'b0, 32'h0000_0001, 5'd17);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("arst_data", bus.rsp_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_ready", 32'(bus.req_ready), 32'd1);
    run(1'b0, 1'b1, 32'h0000_0300, 5'd18);

    // Randomised mix against the model
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        r = $urandom;
        r = r >> $urandom_range(0, 31);
        if ($urandom_range(0, 3) == 0) r = 32'd0 - r;
        run(1'b0, 1'($urandom), r, 5'($urandom));
      end else begin
        r = $urandom;
        if ($urandom_range(0, 3) != 0) r[30:23] = 8'($urandom_range(110, 190));
        run(1'b1, 1'($urandom), r, 5'($urandom));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fcvt_seq_ctrl.md
Name: fcvt_seq_ctrl

Overview:
- Multi-cycle sequencer for FP<->INT conversion (FCVT.S.W/WU, FCVT.W/WU.S), placed between FP issue and writeback.
- Accepts one request at a time over a valid/ready handshake.
- INT->FLOAT is normalised iteratively, one left shift per cycle. FLOAT->INT runs in one execute cycle.
- The result is held on a valid/ready response port until writeback takes it. A pipeline flush can abort the operation at any point.

Parameters:
- TAG_W, 5: width of the request tag (destination register index), returned unchanged with the result.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_op  in  1  0 = INT->FLOAT, 1 = FLOAT->INT.
- req_unsigned  in  1  1 = unsigned integer operand/result.
- req_tag  in  TAG_W  tag echoed on rsp_tag.
- req_src  in  32  source operand (integer or IEEE-754 single).
- flush  in  1  abort in-flight operation.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  writeback accepts result.
- rsp_data  out  32  conversion result.
- rsp_tag  out  TAG_W  tag of result.
- rsp_to_fp  out  1  1 = result goes to FP regfile (INT->FLOAT op), 0 = integer regfile.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; rsp_valid=0, rsp_data=0, rsp_tag=0, rsp_to_fp=0, busy=0. All internal registers cleared. req_ready=1 only once rst_n is high.
- States: IDLE, I2F_NORM, F2I_EXEC, DONE.
- req_ready = (state==IDLE) && !flush.
- Accept: req_valid && req_ready at edge T. Latch op, unsigned, tag, src.
- IDLE -> I2F_NORM on an INT->FLOAT accept:
  - sign = !unsigned && src[31]; mag = sign ? -src : src (32-bit two's complement); exp = 158.
  - If src==0: go directly to DONE with data=0x00000000. rsp_valid is high in cycle T+1.
- I2F_NORM, each cycle:
  - If mag[31]=1: data={sign, exp[7:0], mag[30:8]}, go to DONE.
  - Else: mag<<=1, exp-=1.
  - Truncation only, no rounding.
  - Latency: with the leading one at bit i, rsp_valid is first high at T+2+(31-i). Minimum 2 cycles, maximum 33.
- IDLE -> F2I_EXEC on a FLOAT->INT accept. One cycle, then DONE; rsp_valid is high at T+2.
  - s=src[31], e=src[30:23], f=src[22:0], m={1,f}, sh=e-127 (signed).
  - e==0 && f==0: result 0.
  - sh<0: mag=0.
  - 0<=sh<23: mag = m >> (23-sh).
  - sh>=23: mag = (m << (sh-23)) mod 2^32; sh>=56 gives mag=0.
  - Signed: result = s ? -mag : mag (32-bit wrap, no saturation).
  - Unsigned: result = s ? 0 : mag.
  - NaN/Inf follow the same arithmetic (no special casing).
- DONE: rsp_valid=1; rsp_data, rsp_tag and rsp_to_fp are stable while rsp_valid && !rsp_ready.
  - On rsp_ready: go to IDLE next cycle.
  - A new request cannot be accepted in the same cycle as the response handshake.
- flush (highest priority, any state): next state=IDLE, rsp_valid drops next cycle, result is discarded.
  - This applies even when rsp_ready is high in the same cycle; that response counts as not consumed.
  - No accept occurs in a flush cycle.
- rst_n low mid-operation: immediate return to reset values. No response is produced for the aborted request.
- busy = state != IDLE.
- rsp_data and rsp_tag keep their last values after the handshake; they are meaningful only with rsp_valid.

Test Plan:
- INT->FLOAT signed, src=0x00000001, rsp_ready=1, accept at T -> rsp_data=0x3F800000, rsp_to_fp=1, rsp_valid first high at T+33, then IDLE.
- INT->FLOAT signed src=0xFFFFFFFF -> 0xBF800000 at T+33. Unsigned src=0x80000000 -> 0x4F000000 at T+2. src=0 -> 0x00000000 at T+1.
- FLOAT->INT src=0x40490FDB (3.14159): signed -> 0x00000003; src=0xC0490FDB signed -> 0xFFFFFFFD; unsigned -> 0x00000000. Each at T+2 with rsp_to_fp=0. src=0x3F000000 (0.5) -> 0.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE.
  - rsp_data, rsp_tag and rsp_valid are stable; req_ready=0; a second req_valid is not accepted.
  - Release -> IDLE next cycle, then the second request is accepted.
- Flush: assert flush at T+4 during an INT->FLOAT of 0x00000001 -> IDLE at T+5, no rsp_valid ever for that tag.
  - Flush in DONE with rsp_ready=1 -> rsp_valid drops, no accept that cycle.
- Reset: drive rst_n low asynchronously mid-I2F_NORM -> busy, rsp_valid and rsp_data are 0 immediately. After release, req_ready=1 and a new conversion completes correctly.
